// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor and its synchronizer.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Bits needed to hold the value n; never less than one bit.
  function automatic int ctr_width(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, clearing to zero on reset.
// Also usable by downstream domains to bring sys_reset into their own clock.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises PLL lock: pulses the PLL reset, retries on timeout, faults when
// retries run out, and releases the system reset once lock has held steady.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 2500,
  parameter int LOCK_STABLE    = 256,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lost_count
);

  localparam int CTR_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CTR_MAX   = (CTR_MAX_A > LOCK_STABLE) ? CTR_MAX_A : LOCK_STABLE;
  localparam int CW        = ctr_width(CTR_MAX);
  localparam int RW        = ctr_width(MAX_RETRIES);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

  state_t        state, state_n;
  logic [CW-1:0] ctr, ctr_n;
  logic [RW-1:0] retries, retries_n;
  logic [7:0]    lost_n;
  logic          locked_s;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (pll_locked),
    .q    (locked_s)
  );

  // Next-state, retry and loss bookkeeping.
  always_comb begin
    state_n   = state;
    retries_n = retries;
    lost_n    = lost_count;
    case (state)
      RESET_PLL: begin
        if (ctr == RST_LAST) begin
          state_n = WAIT_LOCK;
        end else begin
          state_n = RESET_PLL;
        end
      end
      WAIT_LOCK: begin
        // Lock arriving on the timeout cycle takes priority over the retry.
        if (locked_s) begin
          state_n = STABLE;
        end else if (ctr == TIMEOUT_LAST) begin
          retries_n = retries + 1'b1;
          if (retries == RETRY_LAST) begin
            state_n = FAULT;
          end else begin
            state_n = RESET_PLL;
          end
        end else begin
          state_n = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
        end else if (ctr == STABLE_LAST) begin
          state_n   = RUN;
          retries_n = '0;
        end else begin
          state_n = STABLE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_n = RESET_PLL;
          if (lost_count != 8'hFF) begin
            lost_n = lost_count + 8'd1;
          end else begin
            lost_n = lost_count;
          end
        end else begin
          state_n = RUN;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = RESET_PLL;
      end
    endcase
  end

  // One counter serves as pulse timer, lock timer and stable window; it
  // restarts on every state change and idles in RUN and FAULT.
  always_comb begin
    ctr_n = ctr;
    if (state_n != state) begin
      ctr_n = '0;
    end else if (state == RESET_PLL || state == WAIT_LOCK || state == STABLE) begin
      ctr_n = ctr + 1'b1;
    end else begin
      ctr_n = ctr;
    end
  end

  // State, counters, and outputs decoded from the upcoming state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RESET_PLL;
      ctr        <= '0;
      retries    <= '0;
      lost_count <= 8'd0;
      pll_rst    <= 1'b1;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      ctr        <= ctr_n;
      retries    <= retries_n;
      lost_count <= lost_n;
      pll_rst    <= (state_n == RESET_PLL);
      sys_reset  <= (state_n != RUN);
      ready      <= (state_n == RUN);
      fault      <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: scenarios queue cycle-stamped expected outputs, and a
// monitor on the falling edge pops and compares them against the DUT.
module tb_pll_lock_supervisor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_reset, ready, fault;
  logic [7:0] lost_count;

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .LOCK_STABLE   (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fault     (fault),
    .lost_count(lost_count)
  );

  always #20 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // {pll_rst, sys_reset, ready, fault} per state
  localparam logic [3:0] O_RP  = 4'b1100;
  localparam logic [3:0] O_WL  = 4'b0100;
  localparam logic [3:0] O_RUN = 4'b0010;
  localparam logic [3:0] O_FLT = 4'b0101;

  typedef struct packed {
    int         at;
    logic [3:0] o;
    logic       lcv;
    logic [7:0] lc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    base = 0;

  task automatic expect_out(input int n, input string nm, input logic [3:0] o, input int lc);
    exp_t e;
    e.at  = base + n;
    e.o   = o;
    e.lcv = (lc >= 0);
    e.lc  = (lc >= 0) ? lc[7:0] : 8'd0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic go_to(input int n);
    while (cyc < base + n) @(negedge clock);
  endtask

  // Asserts reset, fixes cycle 0 two edges later, and queues the reset-value check.
  task automatic start_scn();
    @(negedge clock);
    reset = 1'b1;
    pll_locked = 1'b0;
    base = cyc + 2;
    expect_out(-1, "reset_values", O_RP, 0);
  endtask

  task automatic release_reset();
    go_to(0);
    reset = 1'b0;
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  exp_t  m_e;
  string m_nm;
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      checks++;
      if (m_e.at != cyc || {pll_rst, sys_reset, ready, fault} != m_e.o ||
          (m_e.lcv && lost_count != m_e.lc)) begin
        errors++;
        $display("FAIL %s cycle %0d (due %0d): got rst/sys/rdy/flt=%b lost=%0d, want %b lost=%0d",
                 m_nm, cyc - base, m_e.at - base, {pll_rst, sys_reset, ready, fault},
                 lost_count, m_e.o, m_e.lc);
      end
    end
  end

  initial begin
    int t;
    int k;

    // Nominal lock, then repeated lock losses up to saturation.
    start_scn();
    for (int i = 0; i < 4; i++) expect_out(i, "nom_pll_rst_pulse", O_RP, 0);
    expect_out(4, "nom_wait_lock", O_WL, 0);
    expect_out(12, "nom_pre_stable", O_WL, 0);
    expect_out(20, "nom_last_stable", O_WL, 0);
    expect_out(21, "nom_release", O_RUN, 0);
    expect_out(25, "nom_run_hold", O_RUN, 0);
    expect_out(32, "loss_before", O_RUN, 0);
    expect_out(33, "loss_detect", O_RP, 1);
    expect_out(36, "loss_pulse_end", O_RP, 1);
    expect_out(37, "loss_wait_lock", O_WL, 1);
    expect_out(51, "loss_relock", O_RUN, 1);
    release_reset();
    go_to(10); pll_locked = 1'b1;
    go_to(30); pll_locked = 1'b0;
    go_to(40); pll_locked = 1'b1;
    t = 52;
    for (k = 2; k <= 300; k++) begin
      go_to(t);
      expect_out(t + 3, "loss_repeat_rp", O_RP, (k > 255) ? 255 : k);
      expect_out(t + 21, "loss_repeat_run", O_RUN, (k > 255) ? 255 : k);
      pll_locked = 1'b0;
      go_to(t + 10);
      pll_locked = 1'b1;
      t = t + 22;
    end
    go_to(t);

    // Fault: lock never arrives; reset check also clears the saturated lost_count.
    start_scn();
    expect_out(0, "flt_pulse1", O_RP, 0);
    expect_out(23, "flt_timeout1", O_WL, 0);
    expect_out(24, "flt_pulse2_start", O_RP, 0);
    expect_out(27, "flt_pulse2_end", O_RP, 0);
    expect_out(28, "flt_wait2", O_WL, 0);
    expect_out(47, "flt_timeout2", O_WL, 0);
    for (int i = 0; i <= 10; i++) expect_out(48 + 100 * i, "flt_hold", O_FLT, 0);
    release_reset();
    go_to(1049);

    // Retry then lock on the second attempt.
    start_scn();
    expect_out(23, "retry_timeout", O_WL, 0);
    expect_out(24, "retry_pulse_start", O_RP, 0);
    expect_out(27, "retry_pulse_end", O_RP, 0);
    expect_out(28, "retry_wait2", O_WL, 0);
    expect_out(40, "retry_stable", O_WL, 0);
    expect_out(41, "retry_run", O_RUN, 0);
    release_reset();
    go_to(30); pll_locked = 1'b1;
    go_to(45);

    // One-cycle dropout inside the stable window restarts it.
    start_scn();
    expect_out(21, "bounce_no_early_run", O_WL, 0);
    expect_out(26, "bounce_window_end", O_WL, 0);
    expect_out(27, "bounce_run", O_RUN, 0);
    release_reset();
    go_to(10); pll_locked = 1'b1;
    go_to(15); pll_locked = 1'b0;
    go_to(16); pll_locked = 1'b1;
    go_to(30);

    // Lock on the final timeout cycle wins; retries stay at 1 so the next timeout faults.
    start_scn();
    expect_out(47, "simul_timeout_cycle", O_WL, 0);
    expect_out(48, "simul_lock_wins", O_WL, 0);
    expect_out(53, "simul_back_wait", O_WL, 0);
    expect_out(72, "simul_wait_end", O_WL, 0);
    expect_out(73, "simul_fault", O_FLT, 0);
    release_reset();
    go_to(45); pll_locked = 1'b1;
    go_to(50); pll_locked = 1'b0;
    go_to(76);

    // Reset asserted while in STABLE.
    start_scn();
    expect_out(15, "midrst_stable", O_WL, 0);
    expect_out(16, "midrst_values", O_RP, 0);
    release_reset();
    go_to(10); pll_locked = 1'b1;
    go_to(15); reset = 1'b1;
    go_to(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
